xmega_mul_seq: RTL and testbench

Multi-cycle multiply sequencer for the MEGA/XMEGA core. It replaces the single-cycle 8x8 multiplier array in the ALU with an iterative shift-add datapath. It executes MUL, MULS, MULSU, FMUL, FMULS and FMULSU over several clocks. It drives a busy/done handshake that the core's execute stage uses to stall, and returns the 16-bit product plus updated C/Z flags for the register-file and SREG write-back.

---
 rtl/xmega_mul_seq.sv | 132 +++++++++++++
 tb/tb_xmega_mul_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/xmega_mul_seq.sv
// Iterative shift-add multiplier for MUL/MULS/MULSU/FMUL/FMULS/FMULSU with busy/done handshake.
// Fractional ops are implemented only when XMEGA_MUL_FRACT_EN is defined; otherwise they return R=0.
module xmega_mul_seq #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  op,
  input  logic [7:0]  rd,
  input  logic [7:0]  rr,
  input  logic [7:0]  sreg_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] R,
  output logic [7:0]  sreg_out
);
  localparam int N = 8 / BITS_PER_CYCLE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [7:0]  sreg_q;
  logic [7:0]  mplier;
  logic [15:0] mcand;
  logic [15:0] acc;
  logic        neg_q;

  // issue-time operand decode
  logic       signed_rd, signed_rr;
  logic [7:0] rd_mag, rr_mag;
  logic       neg_d;

  always_comb begin
    signed_rd = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b101);
    signed_rr = (op == 3'b001) || (op == 3'b100);
    rd_mag    = (signed_rd && rd[7]) ? (~rd + 8'd1) : rd;
    rr_mag    = (signed_rr && rr[7]) ? (~rr + 8'd1) : rr;
    neg_d     = (signed_rd & rd[7]) ^ (signed_rr & rr[7]);
  end

  // partial products for the low BITS_PER_CYCLE multiplier bits
  logic [15:0] acc_nxt;
  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < BITS_PER_CYCLE; j++)
      if (mplier[j]) acc_nxt = acc_nxt + (mcand << j);
  end

  // sign fix-up and flag generation
  logic        frac_q;
  logic [15:0] p_fix, r_fix;
  logic [7:0]  s_fix;
  always_comb begin
    frac_q = (op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101);
    p_fix  = neg_q ? (~acc + 16'd1) : acc;
    r_fix  = p_fix;
    s_fix  = sreg_q;
`ifdef XMEGA_MUL_FRACT_EN
    if (frac_q) r_fix = {p_fix[14:0], 1'b0};
    s_fix[0] = p_fix[15];
    s_fix[1] = (r_fix == 16'h0000);
`else
    // unsupported fractional ops report zero and leave SREG untouched so the core can trap
    if (frac_q) begin
      r_fix = 16'h0000;
    end else begin
      s_fix[0] = p_fix[15];
      s_fix[1] = (r_fix == 16'h0000);
    end
`endif
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      op_q     <= 3'd0;
      sreg_q   <= 8'h00;
      mplier   <= 8'h00;
      mcand    <= 16'h0000;
      acc      <= 16'h0000;
      neg_q    <= 1'b0;
      done     <= 1'b0;
      R        <= 16'h0000;
      sreg_out <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            op_q   <= op;
            sreg_q <= sreg_in;
            mplier <= rr_mag;
            mcand  <= {8'h00, rd_mag};
            neg_q  <= neg_d;
            acc    <= 16'h0000;
            cnt    <= 4'(N);
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            acc    <= acc_nxt;
            mplier <= mplier >> BITS_PER_CYCLE;
            mcand  <= mcand << BITS_PER_CYCLE;
            cnt    <= cnt - 4'd1;
            if (cnt == 4'd1) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!kill) begin
            R        <= r_fix;
            sreg_out <= s_fix;
            done     <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xmega_mul_seq.sv
// Self-checking bench for xmega_mul_seq: vector table, hand-written kill/back-to-back/reset
// sequences, and random ops against an arithmetic reference model.
module tb_xmega_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, kill;
  logic [2:0]  op;
  logic [7:0]  rd, rr, sreg_in;
  logic        busy, done;
  logic [15:0] R;
  logic [7:0]  sreg_out;

  int checks = 0;
  int errors = 0;

  xmega_mul_seq #(.BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
    .rd(rd), .rr(rr), .sreg_in(sreg_in), .busy(busy), .done(done),
    .R(R), .sreg_out(sreg_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  rd;
    logic [7:0]  rr;
    logic [7:0]  sreg;
    logic [15:0] er;
    logic [7:0]  es;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: signed/unsigned integer product, then the R/SREG rules.
  function automatic logic [23:0] model(input logic [2:0] o, input logic [7:0] a8,
                                        input logic [7:0] b8, input logic [7:0] s);
    int a, b, p;
    logic [15:0] P, res;
    logic [7:0]  so;
    bit srd, srr, frac;
    srd  = (o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd5);
    srr  = (o == 3'd1) || (o == 3'd4);
    frac = (o == 3'd3) || (o == 3'd4) || (o == 3'd5);
    a = srd ? int'($signed(a8)) : int'(a8);
    b = srr ? int'($signed(b8)) : int'(b8);
    p = a * b;
    P = p[15:0];
    res = P;
    so  = s;
    if (frac) begin
`ifdef XMEGA_MUL_FRACT_EN
      res = {P[14:0], 1'b0};
`else
      return {16'h0000, s};
`endif
    end
    so[0] = P[15];
    so[1] = (res == 16'h0000);
    return {res, so};
  endfunction

  // Waits for done after an issue edge; lat = posedges after issue, bc = busy samples.
  task automatic wait_done(output int lat, output int bc);
    lat = -1;
    bc  = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bc++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] a8,
                        input logic [7:0] b8, input logic [7:0] s, input logic [23:0] exp);
    int lat, bc;
    @(negedge clk);
    op = o; rd = a8; rr = b8; sreg_in = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); rd = 8'($urandom); rr = 8'($urandom); sreg_in = 8'($urandom);
    wait_done(lat, bc);
    chk({name, " latency"}, lat, 5);
    chk({name, " busy cycles"}, bc, 5);
    chk({name, " busy at done"}, busy, 0);
    chk({name, " R"}, R, exp[23:8]);
    chk({name, " sreg_out"}, sreg_out, exp[7:0]);
    @(posedge clk); #1;
    chk({name, " done width"}, done, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int lat, bc, ndone;
    logic [15:0] r_prev;
    logic [7:0]  s_prev;
    logic [23:0] m;

    vecs.push_back('{3'd0, 8'hFF, 8'hFF, 8'h00, 16'hFE01, 8'h01});
    vecs.push_back('{3'd1, 8'h80, 8'h80, 8'h00, 16'h4000, 8'h00});
    vecs.push_back('{3'd2, 8'hFF, 8'hFF, 8'h00, 16'hFF01, 8'h01});
    vecs.push_back('{3'd0, 8'h00, 8'h5A, 8'hFC, 16'h0000, 8'hFE});
    vecs.push_back('{3'd7, 8'h10, 8'h10, 8'hFF, 16'h0100, 8'hFC});
`ifdef XMEGA_MUL_FRACT_EN
    vecs.push_back('{3'd3, 8'h80, 8'h80, 8'h00, 16'h8000, 8'h00});
    vecs.push_back('{3'd5, 8'h80, 8'h02, 8'h00, 16'hFE00, 8'h01});
    vecs.push_back('{3'd4, 8'hC0, 8'hC0, 8'h00, 16'h2000, 8'h00});
`else
    vecs.push_back('{3'd3, 8'h80, 8'h80, 8'h55, 16'h0000, 8'h55});
    vecs.push_back('{3'd5, 8'h80, 8'h02, 8'hA0, 16'h0000, 8'hA0});
`endif

    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    op = 3'd0; rd = 8'h00; rr = 8'h00; sreg_in = 8'h00;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset R", R, 16'h0000);
    chk("reset sreg_out", sreg_out, 8'h00);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rr, vecs[i].sreg,
             {vecs[i].er, vecs[i].es});

    // kill during the third CALC cycle
    r_prev = R; s_prev = sreg_out;
    @(negedge clk);
    op = 3'd0; rd = 8'h12; rr = 8'h34; sreg_in = 8'h00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill busy", busy, 0);
    ndone = done ? 1 : 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("kill no done", ndone, 0);
    chk("kill R kept", R, r_prev);
    chk("kill sreg kept", sreg_out, s_prev);
    run_op("after kill", 3'd0, 8'h03, 8'h04, 8'h00, model(3'd0, 8'h03, 8'h04, 8'h00));

    // kill in IDLE suppresses start
    @(negedge clk);
    op = 3'd0; rd = 8'h05; rr = 8'h05; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b0;
    chk("idle kill busy", busy, 0);

    // back-to-back with start held high
    @(negedge clk);
    op = 3'd0; rd = 8'h02; rr = 8'h03; sreg_in = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    rd = 8'h04; rr = 8'h05;
    wait_done(lat, bc);
    chk("b2b first latency", lat, 5);
    chk("b2b first R", R, 16'h0006);
    @(posedge clk); #1;
    chk("b2b second accepted", busy, 1);
    rd = 8'h77; rr = 8'h66;
    wait_done(lat, bc);
    start = 1'b0;
    chk("b2b second latency", lat, 5);
    chk("b2b second R", R, 16'h0014);
    @(posedge clk); #1;
    chk("b2b no third op", busy, 0);

    // reset mid-CALC
    @(negedge clk);
    op = 3'd0; rd = 8'h99; rr = 8'h77; sreg_in = 8'hFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset R", R, 16'h0000);
    chk("midreset sreg_out", sreg_out, 8'h00);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midreset no done", ndone, 0);
    @(negedge clk); rst_n = 1'b1;

    // random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [2:0] o;
      logic [7:0] a8, b8, s;
      o = 3'($urandom_range(0, 7));
      a8 = 8'($urandom); b8 = 8'($urandom); s = 8'($urandom);
      m = model(o, a8, b8, s);
      run_op($sformatf("rand%0d op%0d %h*%h", i, o, a8, b8), o, a8, b8, s, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
